// File: rtl/act_buffer_reader_if.sv
// act_buffer_reader_if: control, activation-buffer port and consumer stream of act_buffer_reader
// ACT_READER_PERF_EN adds the stall/starve counter outputs
interface act_buffer_reader_if #(
    parameter int intInterfaceWidth = 256,
    parameter int addrWidth = 32
);
    logic start_i;
    logic [addrWidth-1:0] num_words_i;
    logic abort_i;
    logic [addrWidth-1:0] buf_level_i;
    logic buf_rd_en_o;
    logic [intInterfaceWidth-1:0] buf_rd_data_i;
    logic [intInterfaceWidth-1:0] stream_data_o;
    logic stream_valid_o;
    logic stream_ready_i;
    logic busy_o;
    logic done_o;
`ifdef ACT_READER_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_starve_cnt_o;
    modport master(
        input start_i, num_words_i, abort_i, buf_level_i, buf_rd_data_i, stream_ready_i,
        output buf_rd_en_o, stream_data_o, stream_valid_o, busy_o, done_o, perf_stall_cnt_o, perf_starve_cnt_o
    );
    modport slave(
        output start_i, num_words_i, abort_i, buf_level_i, buf_rd_data_i, stream_ready_i,
        input buf_rd_en_o, stream_data_o, stream_valid_o, busy_o, done_o, perf_stall_cnt_o, perf_starve_cnt_o
    );
`else
    modport master(
        input start_i, num_words_i, abort_i, buf_level_i, buf_rd_data_i, stream_ready_i,
        output buf_rd_en_o, stream_data_o, stream_valid_o, busy_o, done_o
    );
    modport slave(
        output start_i, num_words_i, abort_i, buf_level_i, buf_rd_data_i, stream_ready_i,
        input buf_rd_en_o, stream_data_o, stream_valid_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/act_buffer_reader.sv
// act_buffer_reader: streams num_words activation-buffer words through a 2-entry output FIFO
// ACT_READER_PERF_EN adds saturating stall and starve cycle counters
module act_buffer_reader #(
    parameter int intInterfaceWidth = 256,
    parameter int addrWidth = 32
) (
    input logic clk,
    input logic nrst,
    act_buffer_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state;
    logic [addrWidth-1:0] remaining;
    logic inflight;
    logic [1:0] count;
    logic rd_ptr;
    logic wr_ptr;
    logic [intInterfaceWidth-1:0] mem [2];
    logic pop;
    logic rd_en;
    always_comb begin
        pop = (count != 2'd0) && bus.stream_ready_i;
        // a read may only issue if its word is guaranteed a FIFO slot when it returns
        rd_en = (state == READ) && (remaining != '0) && (bus.buf_level_i > addrWidth'(inflight))
            && (3'(count) + 3'(inflight) < 3'd2 + 3'(pop));
    end
    assign bus.buf_rd_en_o = rd_en;
    assign bus.stream_valid_o = count != 2'd0;
    assign bus.stream_data_o = mem[rd_ptr];
    assign bus.busy_o = state != IDLE;
    assign bus.done_o = state == DONE;
    always_ff @(posedge clk) begin
        if (!nrst || bus.abort_i) begin
            state <= IDLE;
            remaining <= '0;
            inflight <= 1'b0;
            count <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            if (!nrst) mem <= '{default: '0};
        end else begin
            inflight <= rd_en;
            if (inflight) begin
                mem[wr_ptr] <= bus.buf_rd_data_i;
                wr_ptr <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + 2'(inflight) - 2'(pop);
            if (rd_en) remaining <= remaining - addrWidth'(1);
            case (state)
                IDLE: if (bus.start_i) begin
                    remaining <= bus.num_words_i;
                    state <= (bus.num_words_i == '0) ? DONE : READ;
                end
                READ: if (rd_en && remaining == addrWidth'(1)) state <= DRAIN;
                // leave DRAIN on the edge that empties the FIFO so DONE follows the last word directly
                DRAIN: if (!inflight && count == {1'b0, pop}) state <= DONE;
                DONE: state <= IDLE;
            endcase
        end
    end
`ifdef ACT_READER_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] starve_cnt;
    always_ff @(posedge clk) begin
        if (!nrst || (state == IDLE && bus.start_i && !bus.abort_i)) begin
            stall_cnt <= '0;
            starve_cnt <= '0;
        end else begin
            if (bus.stream_valid_o && !bus.stream_ready_i && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (state == READ && bus.buf_level_i <= addrWidth'(inflight) && starve_cnt != '1)
                starve_cnt <= starve_cnt + 32'd1;
        end
    end
    assign bus.perf_stall_cnt_o = stall_cnt;
    assign bus.perf_starve_cnt_o = starve_cnt;
`endif
endmodule
